// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It arbitrates memory wait states, a fixed-latency
// divider, load-use hazards and taken branches into hold/flush controls for PC, IF/ID, ID/EX and EX/MEM.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_Rs,
  input  logic [4:0]  id_Rt,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_div_start,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        bubble_ex_mem,
  output logic        div_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // The start cycle is the first of DIV_CYCLES, and cnt==0 marks the last one.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load_use;
  logic             mem_miss;

  assign load_use = ex_MemRead && (ex_wreg != 5'd0) &&
                    ((ex_wreg == id_Rs) || (id_uses_rt && (ex_wreg == id_Rt)));
  assign mem_miss = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stall_pc)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    stall_ex_mem  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    bubble_ex_mem = 1'b0;
    div_done      = 1'b0;

    case (state)
      RUN: begin
        if (mem_miss) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          state_next   = MEM_WAIT;
        end else if (ex_div_start) begin
          stall_pc      = 1'b1;
          stall_if_id   = 1'b1;
          stall_id_ex   = 1'b1;
          bubble_ex_mem = 1'b1;
          cnt_next      = CNT_LOAD;
          state_next    = DIV_BUSY;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (ex_branch_taken) begin
          flush_if_id = 1'b1;
        end
      end

      // A memory miss freezes the divider too; the countdown resumes once memory completes.
      DIV_BUSY: begin
        if (mem_miss) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
        end else if (cnt == '0) begin
          div_done   = 1'b1;
          state_next = RUN;
        end else begin
          stall_pc      = 1'b1;
          stall_if_id   = 1'b1;
          stall_id_ex   = 1'b1;
          bubble_ex_mem = 1'b1;
          cnt_next      = cnt - 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          state_next = RUN;
        end else begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule
